// File: rtl/masked_sbox_scheduler.sv
// masked_sbox_scheduler: arbitrates the SubBytes datapath (requester 0) and
// the key schedule (requester 1) onto one shared, fully pipelined 2-share
// masked AES S-box, attaches fresh randomness to each issued byte, tracks
// in-flight ops and routes results back to their originator. A drain/halt
// handshake lets the top level quiesce the S-box before a mode change.
//
// Build option: define MASKED_SBOX_KEY_PRIORITY_EN to give the key schedule
// fixed priority on conflicts (no round-robin pointer). Default build uses
// round-robin arbitration.
module masked_sbox_scheduler #(
    parameter int unsigned LAT   = 3,
    parameter int unsigned RND_W = 12,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [15:0]          req_sh0,
    input  logic [15:0]          req_sh1,
    input  logic [2*TAG_W-1:0]   req_tag,
    input  logic [RND_W-1:0]     rnd_in,
    input  logic                 rnd_valid,
    output logic                 rnd_ready,
    output logic [7:0]           sbox_in0,
    output logic [7:0]           sbox_in1,
    output logic [RND_W-1:0]     sbox_ran,
    output logic                 sbox_in_valid,
    input  logic [7:0]           sbox_out0,
    input  logic [7:0]           sbox_out1,
    output logic [1:0]           resp_valid,
    output logic [7:0]           resp_sh0,
    output logic [7:0]           resp_sh1,
    output logic [TAG_W-1:0]     resp_tag,
    input  logic                 drain,
    output logic                 idle,
    output logic [2:0]           inflight
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    // Control state
    logic [1:0]         state_q, state_d;
    logic               idle_q, idle_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;

`ifndef MASKED_SBOX_KEY_PRIORITY_EN
    logic               rr_q, rr_d;
`endif

    // Registered S-box operands; held when nothing issues so no share or
    // mask toggles reach the S-box inputs.
    logic [BYTE_W-1:0]  sbox_in0_q, sbox_in0_d;
    logic [BYTE_W-1:0]  sbox_in1_q, sbox_in1_d;
    logic [RND_W-1:0]   sbox_ran_q, sbox_ran_d;
    logic               sbox_in_valid_q, sbox_in_valid_d;

    // Tracking pipeline: LAT stages aligned with the S-box, plus the
    // response register as the final stage (LAT+1 total).
    logic [LAT-1:0]             sr_vld_q, sr_vld_d;
    logic [LAT-1:0]             sr_id_q,  sr_id_d;
    logic [LAT-1:0][TAG_W-1:0]  sr_tag_q, sr_tag_d;
    logic [1:0]                 resp_valid_q, resp_valid_d;
    logic [TAG_W-1:0]           resp_tag_q, resp_tag_d;

    logic               issue_c;
    logic               grant_c;
    logic               ret_c;
    logic [TAG_W-1:0]   grant_tag_c;

    // Arbitration and the combinational request/randomness handshakes
    always_comb begin
        issue_c   = (state_q == ST_RUN) && rnd_valid && (|req_valid);
`ifdef MASKED_SBOX_KEY_PRIORITY_EN
        grant_c   = req_valid[1];
`else
        grant_c   = (&req_valid) ? rr_q : req_valid[1];
`endif
        req_ready = 2'b00;
        if (issue_c) begin
            req_ready = grant_c ? 2'b10 : 2'b01;
        end
        rnd_ready = issue_c;
    end

`ifndef MASKED_SBOX_KEY_PRIORITY_EN
    // Round-robin pointer moves only when a conflict is resolved
    always_comb begin
        rr_d = rr_q;
        if (issue_c && (&req_valid)) begin
            rr_d = ~grant_c;
        end
    end
`endif

    // Operand capture for the granted requester
    always_comb begin
        sbox_in0_d      = sbox_in0_q;
        sbox_in1_d      = sbox_in1_q;
        sbox_ran_d      = sbox_ran_q;
        sbox_in_valid_d = issue_c;
        grant_tag_c     = grant_c ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
        if (issue_c) begin
            sbox_in0_d = grant_c ? req_sh0[15:8] : req_sh0[7:0];
            sbox_in1_d = grant_c ? req_sh1[15:8] : req_sh1[7:0];
            sbox_ran_d = rnd_in;
        end
    end

    // Tag/ID shift register and response decode
    always_comb begin
        sr_vld_d    = sr_vld_q;
        sr_id_d     = sr_id_q;
        sr_tag_d    = sr_tag_q;
        sr_vld_d[0] = issue_c;
        sr_id_d[0]  = grant_c;
        sr_tag_d[0] = grant_tag_c;
        for (int unsigned k = 1; k < LAT; k++) begin
            sr_vld_d[k] = sr_vld_q[k-1];
            sr_id_d[k]  = sr_id_q[k-1];
            sr_tag_d[k] = sr_tag_q[k-1];
        end
        resp_valid_d = 2'b00;
        if (sr_vld_q[LAT-1]) begin
            resp_valid_d = sr_id_q[LAT-1] ? 2'b10 : 2'b01;
        end
        resp_tag_d = sr_tag_q[LAT-1];
    end

    // In-flight counter: +1 on issue, -1 when a response is presented
    always_comb begin
        ret_c      = |resp_valid_q;
        inflight_d = inflight_q + CNT_W'(issue_c) - CNT_W'(ret_c);
    end

    // Run / drain / halt control
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (drain) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!drain) begin
                    state_d = ST_RUN;
                end else if (inflight_q == '0) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!drain) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        idle_d = (state_d == ST_HALT);
    end

    // Control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            idle_q     <= 1'b0;
            inflight_q <= '0;
`ifndef MASKED_SBOX_KEY_PRIORITY_EN
            rr_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idle_q     <= idle_d;
            inflight_q <= inflight_d;
`ifndef MASKED_SBOX_KEY_PRIORITY_EN
            rr_q       <= rr_d;
`endif
        end
    end

    // S-box operand registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbox_in0_q      <= '0;
            sbox_in1_q      <= '0;
            sbox_ran_q      <= '0;
            sbox_in_valid_q <= 1'b0;
        end else begin
            sbox_in0_q      <= sbox_in0_d;
            sbox_in1_q      <= sbox_in1_d;
            sbox_ran_q      <= sbox_ran_d;
            sbox_in_valid_q <= sbox_in_valid_d;
        end
    end

    // Tracking pipeline registers; reset discards in-flight ops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_vld_q     <= '0;
            sr_id_q      <= '0;
            sr_tag_q     <= '0;
            resp_valid_q <= 2'b00;
            resp_tag_q   <= '0;
        end else begin
            sr_vld_q     <= sr_vld_d;
            sr_id_q      <= sr_id_d;
            sr_tag_q     <= sr_tag_d;
            resp_valid_q <= resp_valid_d;
            resp_tag_q   <= resp_tag_d;
        end
    end

    assign sbox_in0      = sbox_in0_q;
    assign sbox_in1      = sbox_in1_q;
    assign sbox_ran      = sbox_ran_q;
    assign sbox_in_valid = sbox_in_valid_q;
    assign resp_valid    = resp_valid_q;
    assign resp_tag      = resp_tag_q;
    // Result shares pass straight through; never recombined here
    assign resp_sh0      = sbox_out0;
    assign resp_sh1      = sbox_out1;
    assign idle          = idle_q;
    assign inflight      = inflight_q;

endmodule

// File: tb/tb_masked_sbox_scheduler.sv
// Bench for masked_sbox_scheduler: behavioural masked S-box stand-in plus a
// queue-based reference model of arbitration, latency and drain behaviour.
module tb_masked_sbox_scheduler;

    localparam int LAT   = 3;
    localparam int RND_W = 12;
    localparam int TAG_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [15:0]        req_sh0, req_sh1;
    logic [2*TAG_W-1:0] req_tag;
    logic [RND_W-1:0]   rnd_in;
    logic               rnd_valid;
    logic               rnd_ready;
    logic [7:0]         sbox_in0, sbox_in1;
    logic [RND_W-1:0]   sbox_ran;
    logic               sbox_in_valid;
    logic [7:0]         sbox_out0, sbox_out1;
    logic [1:0]         resp_valid;
    logic [7:0]         resp_sh0, resp_sh1;
    logic [TAG_W-1:0]   resp_tag;
    logic               drain;
    logic               idle;
    logic [2:0]         inflight;

    masked_sbox_scheduler #(.LAT(LAT), .RND_W(RND_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sh0(req_sh0), .req_sh1(req_sh1), .req_tag(req_tag),
        .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .sbox_in0(sbox_in0), .sbox_in1(sbox_in1), .sbox_ran(sbox_ran),
        .sbox_in_valid(sbox_in_valid),
        .sbox_out0(sbox_out0), .sbox_out1(sbox_out1),
        .resp_valid(resp_valid), .resp_sh0(resp_sh0), .resp_sh1(resp_sh1),
        .resp_tag(resp_tag),
        .drain(drain), .idle(idle), .inflight(inflight)
    );

    always #5 clk = ~clk;

    // Reference AES S-box: GF(2^8) inverse by search, then affine map
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] inv, r1, r2, r3, r4;
        inv = 8'h00;
        for (int c = 1; c < 256; c++) begin
            if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
        end
        r1 = {inv[6:0], inv[7]};
        r2 = {r1[6:0], r1[7]};
        r3 = {r2[6:0], r2[7]};
        r4 = {r3[6:0], r3[7]};
        return inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    endfunction

    // Masked S-box stand-in: 3-stage pipeline, output remasked from sbox_ran
    logic [7:0] sp0 [LAT];
    logic [7:0] sp1 [LAT];
    always @(posedge clk) begin
        logic [7:0] m;
        m = sbox_ran[7:0] ^ sbox_ran[11:4];
        sp0[0] <= aes_sbox(sbox_in0 ^ sbox_in1) ^ m;
        sp1[0] <= m;
        for (int k = 1; k < LAT; k++) begin
            sp0[k] <= sp0[k-1];
            sp1[k] <= sp1[k-1];
        end
    end
    assign sbox_out0 = sp0[LAT-1];
    assign sbox_out1 = sp1[LAT-1];

    // Scoreboard
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model state
    typedef struct {
        int         due;
        logic       id;
        logic [3:0] tag;
        logic [7:0] x;
    } op_t;

    op_t        q[$];
    int         cyc;
    int         mode_m;        // 0 run, 1 draining, 2 halted
    logic       rr_m;
    int         inflight_m;
    logic [7:0] exp_in0, exp_in1;
    logic [11:0] exp_ran;
    logic       exp_vld;
    logic [7:0] last_xor;

    // Requester side: a pending request keeps its data stable until accepted
    logic [1:0] pend;
    logic [7:0] sh0_r [2];
    logic [7:0] sh1_r [2];
    logic [3:0] tag_r [2];

    task automatic model_reset();
        q.delete();
        mode_m = 0; rr_m = 1'b0; inflight_m = 0;
        exp_in0 = 8'h00; exp_in1 = 8'h00; exp_ran = 12'h000; exp_vld = 1'b0;
    endtask

    task automatic gen(input int p_req, input int p_rnd);
        for (int i = 0; i < 2; i++) begin
            if (!pend[i] && ($urandom_range(0, 99) < p_req)) begin
                pend[i]  = 1'b1;
                sh0_r[i] = 8'($urandom);
                sh1_r[i] = 8'($urandom);
                tag_r[i] = 4'($urandom);
            end
        end
        rnd_valid = ($urandom_range(0, 99) < p_rnd);
        rnd_in    = 12'($urandom);
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model
    task automatic run_cycle();
        logic       iss, g, ret;
        logic [1:0] exp_rdy;
        int         next_mode;
        req_valid = pend;
        req_sh0   = {sh0_r[1], sh0_r[0]};
        req_sh1   = {sh1_r[1], sh1_r[0]};
        req_tag   = {tag_r[1], tag_r[0]};
        #4;
        iss = (mode_m == 0) && rnd_valid && (|pend);
`ifdef MASKED_SBOX_KEY_PRIORITY_EN
        g = pend[1];
`else
        g = (pend == 2'b11) ? rr_m : pend[1];
`endif
        exp_rdy = iss ? (g ? 2'b10 : 2'b01) : 2'b00;
        check("req_ready", req_ready, exp_rdy);
        check("rnd_ready", rnd_ready, iss);
        check("sbox_in_valid", sbox_in_valid, exp_vld);
        check("sbox_in0", sbox_in0, exp_in0);
        check("sbox_in1", sbox_in1, exp_in1);
        check("sbox_ran", sbox_ran, exp_ran);
        check("inflight", inflight, inflight_m);
        check("idle", idle, mode_m == 2);
        ret = (q.size() > 0) && (q[0].due == cyc);
        if (ret) begin
            check("resp_valid", resp_valid, q[0].id ? 2'b10 : 2'b01);
            check("resp_tag", resp_tag, q[0].tag);
            check("resp_xor", resp_sh0 ^ resp_sh1, aes_sbox(q[0].x));
            last_xor = resp_sh0 ^ resp_sh1;
            void'(q.pop_front());
        end else begin
            check("resp_valid_idle", resp_valid, 2'b00);
        end
        @(posedge clk);
        #1;
        next_mode = mode_m;
        if (mode_m == 0 && drain) next_mode = 1;
        else if (mode_m == 1 && !drain) next_mode = 0;
        else if (mode_m == 1 && inflight_m == 0) next_mode = 2;
        else if (mode_m == 2 && !drain) next_mode = 0;
        mode_m = next_mode;
        if (ret) inflight_m--;
        if (iss) begin
            q.push_back('{due: cyc + LAT + 1, id: g, tag: tag_r[g], x: sh0_r[g] ^ sh1_r[g]});
            exp_in0 = sh0_r[g];
            exp_in1 = sh1_r[g];
            exp_ran = rnd_in;
            pend[g] = 1'b0;
            if (pend[~g]) rr_m = ~g;
            inflight_m++;
        end
        exp_vld = iss;
        cyc++;
    endtask

    initial begin
        rst = 1'b1; drain = 1'b0; rnd_valid = 1'b0; rnd_in = '0;
        req_valid = 2'b00; req_sh0 = '0; req_sh1 = '0; req_tag = '0;
        pend = 2'b00;
        for (int i = 0; i < 2; i++) begin sh0_r[i] = 8'h00; sh1_r[i] = 8'h00; tag_r[i] = 4'h0; end
        last_xor = 8'h00;
        cyc = 0;
        model_reset();

        // Reset values
        @(posedge clk); @(posedge clk); #1;
        check("rst_in_valid", sbox_in_valid, 0);
        check("rst_in0", sbox_in0, 0);
        check("rst_ran", sbox_ran, 0);
        check("rst_inflight", inflight, 0);
        check("rst_idle", idle, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        rst = 1'b0;

        // Single op from requester 0: 0x53 -> 0xED, tag 5
        pend = 2'b01; sh0_r[0] = 8'h53; sh1_r[0] = 8'h00; tag_r[0] = 4'h5;
        rnd_valid = 1'b1; rnd_in = 12'h3a5;
        run_cycle();
        for (int k = 0; k < 6; k++) begin gen(0, 100); run_cycle(); end
        check("resp_53", last_xor, 8'hED);

        // Both requesters continuously valid: alternation and saturation
        for (int k = 0; k < 6; k++) begin gen(100, 100); run_cycle(); end
        for (int k = 0; k < 8; k++) begin gen(0, 100); run_cycle(); end

        // Randomness starvation with both requesting
        for (int k = 0; k < 3; k++) begin gen(100, 0); run_cycle(); end
        for (int k = 0; k < 8; k++) begin gen(0, 100); run_cycle(); end

        // Drain raised on the second of three back-to-back handshakes
        gen(100, 100); run_cycle();
        drain = 1'b1;
        gen(100, 100); run_cycle();
        for (int k = 0; k < 10; k++) begin gen(100, 100); run_cycle(); end
        check("drain_halted", idle, 1);
        drain = 1'b0;
        for (int k = 0; k < 4; k++) begin gen(100, 100); run_cycle(); end
        for (int k = 0; k < 8; k++) begin gen(0, 100); run_cycle(); end

        // Randomized traffic with occasional drain toggling
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 99) < 4) drain = ~drain;
            gen(60, 75);
            run_cycle();
        end
        drain = 1'b0;
        for (int k = 0; k < 8; k++) begin gen(0, 100); run_cycle(); end

        // Asynchronous reset with three ops in flight
        for (int k = 0; k < 3; k++) begin gen(100, 100); run_cycle(); end
        check("pre_rst_inflight", inflight, 3);
        #2 rst = 1'b1;
        #1;
        check("arst_in_valid", sbox_in_valid, 0);
        check("arst_in0", sbox_in0, 0);
        check("arst_in1", sbox_in1, 0);
        check("arst_ran", sbox_ran, 0);
        check("arst_inflight", inflight, 0);
        check("arst_idle", idle, 0);
        check("arst_resp_valid", resp_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc++;
        model_reset();
        pend = 2'b00;
        for (int k = 0; k < LAT + 4; k++) begin gen(0, 100); run_cycle(); end

        // Short random tail after reset
        for (int k = 0; k < 40; k++) begin gen(50, 80); run_cycle(); end
        for (int k = 0; k < 8; k++) begin gen(0, 100); run_cycle(); end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/masked_sbox_scheduler.md
Name: masked_sbox_scheduler

Overview:
- Arbitrates two requesters (0 = SubBytes datapath, 1 = key schedule) onto one shared, fully pipelined, 2-share first-order PINI masked AES S-box (Canright, 3-cycle).
- Attaches fresh randomness to every issued byte and tracks in-flight ops in a tag/ID shift register.
- Routes S-box results back to the originating requester.
- Provides a drain/halt mechanism so the top level can quiesce the S-box before a mode change.

Parameters:
LAT, 3, S-box pipeline latency in cycles from sbox_in_valid to the matching sbox_out
RND_W, 12, randomness bits consumed per issued byte
TAG_W, 4, requester tag width, returned unchanged with the result

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  2  per-requester request valid, bit i = requester i
req_ready  out  2  per-requester accept, combinational
req_sh0  in  16  share 0 bytes, [8i+7:8i] = requester i
req_sh1  in  16  share 1 bytes, same packing
req_tag  in  2*TAG_W  per-requester tag
rnd_in  in  RND_W  fresh randomness from PRNG
rnd_valid  in  1  rnd_in usable this cycle
rnd_ready  out  1  rnd_in consumed this cycle
sbox_in0  out  8  share 0 to S-box, registered
sbox_in1  out  8  share 1 to S-box, registered
sbox_ran  out  RND_W  randomness to S-box, registered
sbox_in_valid  out  1  registered issue strobe
sbox_out0  in  8  S-box result share 0
sbox_out1  in  8  S-box result share 1
resp_valid  out  2  result valid for requester i, no back-pressure
resp_sh0  out  8  result share 0, broadcast to both requesters
resp_sh1  out  8  result share 1, broadcast to both requesters
resp_tag  out  TAG_W  tag of the returning op
drain  in  1  stop accepting and empty the pipeline
idle  out  1  pipeline empty and halted
inflight  out  3  number of ops issued and not yet returned (0..LAT+1)

Behaviour:
- Reset (async): rr pointer=0; state=RUN; sbox_in0/1, sbox_ran, sbox_in_valid=0; shift register cleared; inflight=0; idle=0; resp_valid=0. In-flight ops are discarded with no response.
- Issue condition: state==RUN && rnd_valid && |req_valid.
- Grant when one requester is valid: that requester.
- Grant when both are valid: requester rr; rr then flips to the other requester. rr updates only on a grant.
- req_ready[i] = issue && grant==i; rnd_ready = issue. At most one handshake per cycle.
- On issue at cycle t: the granted shares, tag and rnd_in are registered. sbox_in_valid=1 in cycle t+1.
- No issue: sbox_in0/1 and sbox_ran hold their previous values so that no share or mask transition occurs, and sbox_in_valid=0.
- Shift register depth LAT+1 carries {valid, id, tag}. resp_valid[id] asserts in cycle t+1+LAT.
- In that cycle: resp_sh0/1 = sbox_out0/1 (combinational pass-through) and resp_tag = the stored tag. Handshake-to-response latency is LAT+1 = 4.
- Response shares are never recombined or registered in this block.
- inflight: +1 on issue, -1 on return. Both in the same cycle leaves it unchanged. Back-to-back issue is sustained at 1/cycle indefinitely.
- FSM:
  - RUN: drain=1 goes to DRAIN. Grants are blocked from the cycle drain is seen.
  - DRAIN: no grants; when inflight==0 goes to HALT.
  - HALT: idle=1; drain=0 goes to RUN the next cycle. idle drops with the transition.
- Deasserting drain while in DRAIN returns to RUN without waiting for empty.
- rnd_valid=0 stalls issue regardless of requests. Requesters keep valid asserted and their data stable until ready.

Optional Feature:
- Macro MASKED_SBOX_KEY_PRIORITY_EN.
- Defined: fixed priority, requester 1 (key schedule) always wins a conflict, and the rr pointer is removed.
- Undefined: round-robin as above.

Test Plan:
- Reset, then req_valid=01, sh0=0x53, sh1=0x00, tag=5, rnd_valid=1 -> req_ready=01 same cycle; sbox_in_valid next cycle; resp_valid=01 four cycles after handshake, tag=5, resp_sh0^resp_sh1=0xED.
- Both requesters valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; inflight saturates at 4; responses return in issue order with matching tags.
- rnd_valid low for 3 cycles with req_valid=11 -> req_ready=00 and sbox_in0/1 and sbox_ran unchanged; issue resumes on the first cycle rnd_valid=1.
- Issue 3 ops back-to-back, assert drain on the 2nd handshake cycle -> third op not granted; idle=1 one cycle after inflight reaches 0; release drain -> idle=0 and next request granted one cycle later.
- Assert rst asynchronously with 3 ops in flight -> all outputs zero immediately; no resp_valid afterwards; inflight=0.
- With MASKED_SBOX_KEY_PRIORITY_EN and req_valid=11 for 4 cycles -> requester 1 granted all 4 cycles, requester 0 never granted.
